// File: rtl/hero_run_sprite_fetch.sv
// Sprite ROM address generator and colour-index stage for the running hero.
// Latches hero position per video frame and sequences the run animation.
module hero_run_sprite_fetch #(
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int N_FRAMES    = 5,
    parameter int HOLD_FRAMES = 4,
    parameter int ROM_AW      = 13
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_start,
    input  logic              running,
    input  logic              facing_left,
    input  logic [9:0]        HeroX,
    input  logic [9:0]        HeroY,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [2:0]        rom_q,
    output logic [2:0]        pal_index,
    output logic              hero_on,
    output logic [2:0]        frame_idx
);

    localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [31:0] SW  = SPR_W;
    localparam logic [31:0] SH  = SPR_H;
    localparam logic [31:0] FSZ = SPR_W * SPR_H;

    typedef enum logic {STAND, RUN} state_t;

    state_t            state;
    logic [HW-1:0]     hold_cnt;
    logic [9:0]        herox_q;
    logic [9:0]        heroy_q;
    logic              facing_q;
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic              in_box;
    logic              in_box_d1;
    logic              in_box_d2;
    logic [31:0]       col;
    logic [ROM_AW-1:0] addr;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= STAND;
            hold_cnt  <= '0;
            frame_idx <= '0;
            herox_q   <= '0;
            heroy_q   <= '0;
            facing_q  <= 1'b0;
        end else if (frame_start) begin
            herox_q  <= HeroX;
            heroy_q  <= HeroY;
            facing_q <= facing_left;
            unique case (state)
                STAND: begin
                    if (running) begin
                        state     <= RUN;
                        hold_cnt  <= (HOLD_FRAMES > 1) ? HW'(1) : '0;
                        frame_idx <= '0;
                    end
                end
                RUN: begin
                    if (!running) begin
                        state     <= STAND;
                        hold_cnt  <= '0;
                        frame_idx <= '0;
                    end else if (hold_cnt == HW'(HOLD_FRAMES - 1)) begin
                        hold_cnt  <= '0;
                        frame_idx <= (frame_idx == 3'(N_FRAMES - 1)) ?
                                     3'd0 : frame_idx + 3'd1;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
            endcase
        end
    end

    // Zero-extended 11-bit subtraction: negative offsets never alias into the box.
    always_comb begin
        dx     = $signed({1'b0, DrawX}) - $signed({1'b0, herox_q});
        dy     = $signed({1'b0, DrawY}) - $signed({1'b0, heroy_q});
        in_box = !dx[10] && (32'(dx[9:0]) < SW) &&
                 !dy[10] && (32'(dy[9:0]) < SH);
        col    = facing_q ? (SW - 32'd1 - 32'(dx[9:0])) : 32'(dx[9:0]);
        addr   = ROM_AW'(32'(frame_idx) * FSZ + 32'(dy[9:0]) * SW + col);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr  <= '0;
            in_box_d1 <= 1'b0;
            in_box_d2 <= 1'b0;
            pal_index <= '0;
            hero_on   <= 1'b0;
        end else begin
            rom_addr  <= in_box ? addr : '0;
            in_box_d1 <= in_box;
            in_box_d2 <= in_box_d1;
            pal_index <= in_box_d2 ? rom_q : 3'd0;
            hero_on   <= in_box_d2 && (rom_q != 3'd0);
        end
    end

endmodule

// File: tb/tb_hero_run_sprite_fetch.sv
// Bench for hero_run_sprite_fetch: directed vectors, corner sequences and
// randomized traffic against a frame-count based reference model.
module tb_hero_run_sprite_fetch;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        running = 1'b0;
    logic        facing_left = 1'b0;
    logic [9:0]  HeroX = '0;
    logic [9:0]  HeroY = '0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic [12:0] rom_addr;
    logic [2:0]  rom_q = '0;
    logic [2:0]  pal_index;
    logic        hero_on;
    logic [2:0]  frame_idx;

    logic [2:0]  mem [8192];
    int          errors = 0;
    int          checks = 0;

    int          m_hx, m_hy, m_k;
    bit          m_face;
    int          expq[$];

    typedef struct {
        int hx;
        int hy;
        bit face;
        int dx;
        int dy;
        int fi;
        int addr;
        bit inb;
    } vec_t;

    vec_t vecs[10];

    hero_run_sprite_fetch dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .frame_start(frame_start),
        .running(running),
        .facing_left(facing_left),
        .HeroX(HeroX),
        .HeroY(HeroY),
        .DrawX(DrawX),
        .DrawY(DrawY),
        .rom_addr(rom_addr),
        .rom_q(rom_q),
        .pal_index(pal_index),
        .hero_on(hero_on),
        .frame_idx(frame_idx)
    );

    always #5 Clk = ~Clk;

    // Synchronous sprite ROM, one cycle of read latency
    always @(posedge Clk) rom_q <= mem[rom_addr];

    function automatic int model_fi();
        return (m_k / 4) % 5;
    endfunction

    function automatic int model_pix(int x, int y);
        int ddx = x - m_hx;
        int ddy = y - m_hy;
        int c;
        int a;
        if (ddx < 0 || ddx >= 32 || ddy < 0 || ddy >= 32) return 0;
        c = m_face ? 31 - ddx : ddx;
        a = (model_fi() * 1024 + ddy * 32 + c) % 8192;
        return int'(mem[a]);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_hx = 0;
        m_hy = 0;
        m_face = 0;
        m_k = 0;
        expq.delete();
        repeat (3) expq.push_back(0);
    endtask

    task automatic step(input bit fs, input bit run, input bit face,
                        input int hx, input int hy,
                        input int dxv, input int dyv);
        int e;
        @(negedge Clk);
        chk("frame_idx", frame_idx, model_fi());
        if (expq.size() == 0) begin
            chk("pipe_queue", 0, 1);
        end else begin
            e = expq.pop_front();
            chk("pal_index", pal_index, e);
            chk("hero_on", hero_on, int'(e != 0));
        end
        frame_start = fs;
        running = run;
        facing_left = face;
        HeroX = 10'(hx);
        HeroY = 10'(hy);
        DrawX = 10'(dxv);
        DrawY = 10'(dyv);
        expq.push_back(model_pix(dxv & 1023, dyv & 1023));
        if (fs) begin
            m_hx = hx & 1023;
            m_hy = hy & 1023;
            m_face = face;
            m_k = run ? (m_k + 1) % 20 : 0;
        end
    endtask

    task automatic pulse(input bit run);
        step(1, run, m_face, m_hx, m_hy, 1000, 1000);
        step(0, run, m_face, m_hx, m_hy, 1000, 1000);
    endtask

    task automatic reset_pulse();
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_pal_index", pal_index, 0);
        chk("rst_hero_on", hero_on, 0);
        chk("rst_frame_idx", frame_idx, 0);
        @(negedge Clk);
        frame_start = 1'b0;
        DrawX = 10'd1000;
        DrawY = 10'd1000;
        Reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int guard;
        for (int a = 0; a < 8192; a++) mem[a] = 3'((a % 7) + 1);
        vecs[0] = '{100, 200, 0, 105, 210, 2, 2373, 1};
        vecs[1] = '{100, 200, 1, 105, 210, 2, 2394, 1};
        vecs[2] = '{100, 200, 0,  99, 210, 2,    0, 0};
        vecs[3] = '{100, 200, 0, 132, 210, 2,    0, 0};
        vecs[4] = '{100, 200, 0, 131, 210, 3, 3423, 1};
        vecs[5] = '{620, 200, 0, 639, 210, 3, 3411, 1};
        vecs[6] = '{620, 200, 1, 639, 210, 3, 3404, 1};
        vecs[7] = '{100, 200, 0, 100, 199, 3,    0, 0};
        vecs[8] = '{100, 200, 0, 100, 231, 4, 5088, 1};
        vecs[9] = '{100, 200, 0, 100, 232, 4,    0, 0};

        repeat (2) @(negedge Clk);
        chk("init_rom_addr", rom_addr, 0);
        chk("init_pal_index", pal_index, 0);
        chk("init_hero_on", hero_on, 0);
        chk("init_frame_idx", frame_idx, 0);
        DrawX = 10'd1000;
        DrawY = 10'd1000;
        Reset_n = 1'b1;
        model_reset();

        for (int k = 1; k <= 20; k++) begin
            pulse(1);
            chk($sformatf("anim_k%0d", k), frame_idx, (k / 4) % 5);
        end
        chk("anim_end", frame_idx, 0);

        repeat (12) pulse(1);
        chk("pre_rst_fi", frame_idx, 3);
        reset_pulse();
        pulse(1);
        chk("post_rst_fi", frame_idx, 0);
        repeat (3) pulse(1);
        chk("post_rst_run", frame_idx, 1);

        repeat (3) pulse(1);
        foreach (vecs[i]) begin
            step(1, 1, vecs[i].face, vecs[i].hx, vecs[i].hy,
                 vecs[i].dx, vecs[i].dy);
            step(0, 1, vecs[i].face, vecs[i].hx, vecs[i].hy,
                 vecs[i].dx, vecs[i].dy);
            chk($sformatf("vec%0d_fi", i), frame_idx, vecs[i].fi);
            step(0, 1, vecs[i].face, vecs[i].hx, vecs[i].hy, 1000, 1000);
            chk($sformatf("vec%0d_addr", i), rom_addr, vecs[i].addr);
            step(0, 1, vecs[i].face, vecs[i].hx, vecs[i].hy, 1000, 1000);
            step(0, 1, vecs[i].face, vecs[i].hx, vecs[i].hy, 1000, 1000);
            chk($sformatf("vec%0d_on", i), hero_on, int'(vecs[i].inb));
            chk($sformatf("vec%0d_pal", i), pal_index,
                vecs[i].inb ? (vecs[i].addr % 7) + 1 : 0);
        end

        step(1, 1, 0, 100, 200, 1000, 1000);
        mem[4421] = 3'd0;
        step(0, 1, 0, 100, 200, 105, 210);
        step(0, 1, 0, 100, 200, 1000, 1000);
        chk("transp_addr", rom_addr, 4421);
        step(0, 1, 0, 100, 200, 1000, 1000);
        step(0, 1, 0, 100, 200, 1000, 1000);
        chk("transp_pal", pal_index, 0);
        chk("transp_on", hero_on, 0);
        mem[4421] = 3'd5;
        step(0, 1, 0, 100, 200, 105, 210);
        step(0, 1, 0, 100, 200, 1000, 1000);
        chk("lat1_pal", pal_index, 0);
        step(0, 1, 0, 100, 200, 1000, 1000);
        chk("lat2_pal", pal_index, 0);
        step(0, 1, 0, 100, 200, 1000, 1000);
        chk("lat3_pal", pal_index, 5);
        chk("lat3_on", hero_on, 1);
        step(0, 1, 0, 100, 200, 1000, 1000);
        chk("lat4_pal", pal_index, 0);
        chk("lat4_on", hero_on, 0);

        guard = 0;
        while (m_k != 12 && guard < 40) begin
            pulse(1);
            guard++;
        end
        chk("stop_pre", frame_idx, 3);
        step(1, 0, 0, 100, 200, 1000, 1000);
        step(0, 0, 0, 100, 200, 1000, 1000);
        chk("stop_fi", frame_idx, 0);
        step(1, 0, 0, 100, 200, 1000, 1000);
        step(0, 0, 0, 300, 200, 105, 210);
        step(0, 0, 0, 300, 200, 1000, 1000);
        chk("latch_old", rom_addr, 325);
        step(1, 0, 0, 300, 200, 1000, 1000);
        step(0, 0, 0, 300, 200, 305, 210);
        step(0, 0, 0, 300, 200, 1000, 1000);
        chk("latch_new", rom_addr, 325);
        step(0, 0, 0, 300, 200, 105, 210);
        step(0, 0, 0, 300, 200, 1000, 1000);
        chk("latch_new_out", rom_addr, 0);

        repeat (3) step(0, 0, 0, 300, 200, 1000, 1000);
        for (int a = 0; a < 8192; a++) mem[a] = 3'($urandom_range(0, 7));
        for (int n = 0; n < 3000; n++) begin
            bit fs, run, face;
            int hx, hy, dxv, dyv;
            fs = ($urandom_range(0, 7) == 0);
            run = ($urandom_range(0, 3) != 0);
            face = 1'($urandom_range(0, 1));
            hx = $urandom_range(0, 639);
            hy = $urandom_range(0, 479);
            if ($urandom_range(0, 3) == 0) begin
                dxv = $urandom_range(0, 1023);
                dyv = $urandom_range(0, 1023);
            end else begin
                dxv = m_hx + $urandom_range(0, 40) - 4;
                dyv = m_hy + $urandom_range(0, 40) - 4;
            end
            step(fs, run, face, hx, hy, dxv, dyv);
        end
        repeat (4) step(0, 0, 0, 0, 0, 1000, 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hero_run_sprite_fetch.md
# hero_run_sprite_fetch

Upstream feeder for the hero running-animation palette lookup. Each pixel clock it takes the VGA raster position and the hero's screen position and produces the sprite ROM address. It then registers the ROM's 3-bit colour index into `pal_index`, which drives the palette's `index` input directly. It also sequences the 5-frame running animation on frame boundaries, mirrors the sprite when the hero faces left, and flags transparent (index 0, chroma green 0x0E0) pixels so the compositor can ignore them.

## Interface
- `SPR_W`, default 32: sprite width in pixels; must be a power of two.
- `SPR_H`, default 32: sprite height in pixels.
- `N_FRAMES`, default 5: animation frames stored back-to-back in ROM.
- `HOLD_FRAMES`, default 4: video frames each animation frame is displayed.
- `ROM_AW`, default 13: ROM address width; ≥ clog2(N_FRAMES·SPR_W·SPR_H).
- `Clk` in, 1: pixel clock.
- `Reset_n` in, 1: reset, asynchronous assert, active-low.
- `frame_start` in, 1: one-cycle pulse at start of vertical blank.
- `running` in, 1: hero is moving.
- `facing_left` in, 1: mirror sprite horizontally.
- `HeroX`, `HeroY` in, 10 each: sprite top-left screen coordinate.
- `DrawX`, `DrawY` in, 10 each: current raster pixel.
- `rom_addr` out, ROM_AW: address to synchronous sprite ROM (1-cycle read latency).
- `rom_q` in, 3: ROM data, valid one cycle after `rom_addr`.
- `pal_index` out, 3: colour index to palette.
- `hero_on` out, 1: opaque hero pixel at this position.
- `frame_idx` out, 3: current animation frame.

## Operation
- **Frame-boundary latching.** On `frame_start` the block latches `HeroX`, `HeroY` and `facing_left` into shadow registers. Position and facing changes mid-frame have no effect until the next `frame_start`.
- **Animation FSM, two states, STAND and RUN.** The FSM evaluates only on cycles with `frame_start`=1; otherwise it holds.
  - STAND: `frame_idx`=0 and `hold_cnt`=0. If `running`=1, go to RUN; `frame_idx` stays 0 and `hold_cnt` becomes 1.
  - RUN with `running`=1: `hold_cnt` increments. When `hold_cnt`=HOLD_FRAMES-1, `hold_cnt` is set to 0 instead and `frame_idx` advances. After N_FRAMES-1, `frame_idx` wraps to 0.
  - RUN with `running`=0: go to STAND, with `frame_idx`=0 and `hold_cnt`=0.
  - The value of `running` sampled is the one in the same cycle as `frame_start`.
- **Box test.** Compute dx = DrawX − HeroX_q and dy = DrawY − HeroY_q in 11-bit signed arithmetic. in_box = (0 ≤ dx < SPR_W) && (0 ≤ dy < SPR_H). There is no wrap-around at the right or bottom screen edges.
- **Mirroring.** col = facing_q ? SPR_W−1−dx : dx.
- **Addressing.** addr = frame_idx·SPR_W·SPR_H + dy·SPR_W + col, truncated to ROM_AW bits. When in_box=0, addr = 0.
- **Output stage.**
  - `pal_index` = in_box_d2 ? `rom_q` : 0.
  - `hero_on` = in_box_d2 && (`rom_q` ≠ 0).

## Timing
- Reset (`Reset_n`=0, asynchronous): all outputs are 0, the FSM is in STAND, all shadow and pipeline registers are 0. Reset asserted mid-animation aborts immediately. Operation resumes on the first rising `Clk` edge after deassertion.
- Pipeline, with DrawX/DrawY sampled at edge t:
  - `rom_addr` and in_box_d1 are registered at t+1.
  - `rom_q` is returned by the ROM and in_box_d2 is registered at t+2.
  - `pal_index` and `hero_on` are registered at t+3.
  - Total latency from raster to outputs is 3 cycles. The compositor delays DrawX/DrawY to match.
- `frame_idx` and the shadow registers update on the edge that samples `frame_start`=1, and take effect for the next cycle's address.
- Throughput is one pixel per clock, with no stalls.

## Test plan
- **Reset.** Run the animation to `frame_idx`=3, then pulse `Reset_n`=0 mid-line. Required: all outputs are 0 asynchronously; after release, the first `frame_start` with `running`=1 enters RUN with `frame_idx`=0.
- **Animation sequence.** Hold `running`=1 and apply 20 `frame_start` pulses. Required: after pulse k, `frame_idx` = ⌊k/4⌋ mod 5; after pulse 20, `frame_idx`=0.
- **Addressing and mirroring.** HeroX=100, HeroY=200, `frame_idx`=2, facing right, DrawX=105, DrawY=210. Required: `rom_addr`=2373 one cycle later. With facing left latched, required: `rom_addr`=2394.
- **Box edges.** With HeroX=100, DrawX=99 and DrawX=132 must give `hero_on`=0 and `pal_index`=0. DrawX=131 must be in-box. With HeroX=620, DrawX=639 must be in-box with dx=19 and no wrap.
- **Transparency and latency.** In-box pixel with `rom_q`=0: required `pal_index`=0 and `hero_on`=0. With `rom_q`=5: required `pal_index`=5 and `hero_on`=1, exactly 3 cycles after the DrawX sample.
- **Stop and latch.** `running`=0 at a `frame_start` while `frame_idx`=3: required `frame_idx`=0 on the next cycle. HeroX changed from 100 to 300 mid-frame: addresses still use 100 until the next `frame_start`.
